// File: rtl/acq_ram_writer_pkg.sv
// rtl/acq_ram_writer_pkg.sv - shared flag positions and state encodings for the acquisition RAM writer
// Purpose: word flag bit positions (shared with the disc reader) and the
//          sequencer / write-engine state types.
package acq_ram_writer_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAITIDX = 3'd1,
        S_ACQ     = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } seq_state_e;

    // SRAM write engine states; one word per trip around the loop
    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_SETUP  = 2'd1,
        W_STROBE = 2'd2,
        W_HOLD   = 2'd3
    } wr_state_e;

    // Index flag sits just below the data flag at the top of the word
    function automatic int idx_bit(input int bits);
        return bits - 2;
    endfunction

    function automatic int dat_bit(input int bits);
        return bits - 1;
    endfunction

endpackage

// File: rtl/acq_sync_fifo.sv
// rtl/acq_sync_fifo.sv - single-clock FIFO with synchronous flush
// Purpose: buffers reader words ahead of the SRAM write engine.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               empties the FIFO; overrides push and pop
//   push, push_data     write request and word; ignored when full unless popping
//   pop, pop_data       read request and head word (valid while !empty)
//   full, empty         occupancy flags
module acq_sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Pointers carry one extra wrap bit to tell full from empty
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic                pop_en;
    logic                wr_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                      (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign pop_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign pop_en   = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle
    assign wr_en    = push && (!full || pop_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/acq_ram_writer.sv
// rtl/acq_ram_writer.sv - sequences a disc acquisition and writes reader words into SRAM
// Purpose: buffers the reader word stream, commits each word to SRAM with a
//          setup/strobe/hold cycle, and runs the acquisition sequence.
// Ports:
//   CLOCK, RESET                clock, asynchronous active-low reset
//   START, ABORT                one-cycle host command pulses
//   WAIT_INDEX, INDEX_STOP      acquisition options
//   RD_DATA, RD_WRITE           word stream from the disc reader
//   RUN                         reader enable
//   SRAM_A, SRAM_D, SRAM_WE_N   SRAM write port
//   BUSY, WORDS, FULL, OVERRUN  status
module acq_ram_writer
    import acq_ram_writer_pkg::*;
#(
    parameter int BITS            = 16,
    parameter int ADDR_BITS       = 19,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 WAIT_INDEX,
    input  logic [7:0]           INDEX_STOP,
    input  logic [BITS-1:0]      RD_DATA,
    input  logic                 RD_WRITE,
    output logic                 RUN,
    output logic [ADDR_BITS-1:0] SRAM_A,
    output logic [BITS-1:0]      SRAM_D,
    output logic                 SRAM_WE_N,
    output logic                 BUSY,
    output logic [ADDR_BITS-1:0] WORDS,
    output logic                 FULL,
    output logic                 OVERRUN
);

    localparam int IDX = idx_bit(BITS);

    seq_state_e           seq_q, seq_d;
    wr_state_e            wr_q, wr_d;
    logic [ADDR_BITS-1:0] sram_a_q, sram_a_d;
    logic [BITS-1:0]      sram_d_q, sram_d_d;
    logic [ADDR_BITS-1:0] words_q, words_d;
    logic                 full_q, full_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           idx_cnt_q, idx_cnt_d;

    logic            active;
    logic            start_act;
    logic            abort_act;
    logic            rd_idx;
    logic            push_req;
    logic            push_ok;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic            fifo_empty;
    logic [BITS-1:0] fifo_rdata;

    assign active    = (seq_q == S_WAITIDX) || (seq_q == S_ACQ) || (seq_q == S_DRAIN);
    assign abort_act = ABORT && active;
    // ABORT beats a simultaneous START
    assign start_act = START && !ABORT && ((seq_q == S_IDLE) || (seq_q == S_DONE));
    assign rd_idx    = RD_DATA[IDX];

    // Before the first index only index-flagged words get in; once FULL nothing does,
    // so late strobes never count as overruns.
    assign push_req  = RD_WRITE && !abort_act && !full_q &&
                       ((seq_q == S_ACQ) || ((seq_q == S_WAITIDX) && rd_idx));
    // No new write starts on an abort cycle: the queue is being thrown away
    assign fifo_pop  = (wr_q == W_IDLE) && !fifo_empty && !full_q && !abort_act;
    assign push_ok   = push_req && (!fifo_full || fifo_pop);
    assign fifo_flush = start_act || abort_act || full_q;

    acq_sync_fifo #(
        .WIDTH      (BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (CLOCK),
        .rst_n     (RESET),
        .flush     (fifo_flush),
        .push      (push_ok),
        .push_data (RD_DATA),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        seq_d     = seq_q;
        wr_d      = wr_q;
        sram_a_d  = sram_a_q;
        sram_d_d  = sram_d_q;
        words_d   = words_q;
        full_d    = full_q;
        overrun_d = overrun_q;
        idx_cnt_d = idx_cnt_q;

        if (push_req && fifo_full && !fifo_pop) begin
            overrun_d = 1'b1;
        end

        // Write engine
        case (wr_q)
            W_IDLE: begin
                if (fifo_pop) begin
                    wr_d     = W_SETUP;
                    sram_a_d = words_q;
                    sram_d_d = fifo_rdata;
                end
            end
            W_SETUP:  wr_d = W_STROBE;
            W_STROBE: wr_d = W_HOLD;
            W_HOLD: begin
                wr_d = W_IDLE;
                if (sram_a_q == {ADDR_BITS{1'b1}}) begin
                    // Last address written: WORDS stays pinned at all-ones
                    full_d = 1'b1;
                end else begin
                    words_d = words_q + 1'b1;
                end
            end
            default: wr_d = W_IDLE;
        endcase

        // Sequencer
        case (seq_q)
            S_IDLE, S_DONE: begin
                if (start_act) begin
                    seq_d     = WAIT_INDEX ? S_WAITIDX : S_ACQ;
                    words_d   = '0;
                    full_d    = 1'b0;
                    overrun_d = 1'b0;
                    idx_cnt_d = '0;
                end
            end
            S_WAITIDX: begin
                if (abort_act || full_q) begin
                    seq_d = S_DRAIN;
                end else if (push_ok) begin
                    idx_cnt_d = 8'd1;
                    seq_d     = (INDEX_STOP == 8'd1) ? S_DRAIN : S_ACQ;
                end
            end
            S_ACQ: begin
                if (abort_act || full_q) begin
                    seq_d = S_DRAIN;
                end else if (push_ok && rd_idx) begin
                    idx_cnt_d = idx_cnt_q + 8'd1;
                    if ((INDEX_STOP != 8'd0) && (idx_cnt_d == INDEX_STOP)) begin
                        seq_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty && (wr_q == W_IDLE)) begin
                    seq_d = S_DONE;
                end
            end
            default: seq_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            seq_q     <= S_IDLE;
            wr_q      <= W_IDLE;
            sram_a_q  <= '0;
            sram_d_q  <= '0;
            words_q   <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            idx_cnt_q <= '0;
        end else begin
            seq_q     <= seq_d;
            wr_q      <= wr_d;
            sram_a_q  <= sram_a_d;
            sram_d_q  <= sram_d_d;
            words_q   <= words_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            idx_cnt_q <= idx_cnt_d;
        end
    end

    assign RUN       = (seq_q == S_WAITIDX) || (seq_q == S_ACQ);
    assign BUSY      = active;
    assign SRAM_WE_N = (wr_q != W_STROBE);
    assign SRAM_A    = sram_a_q;
    assign SRAM_D    = sram_d_q;
    assign WORDS     = words_q;
    assign FULL      = full_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_acq_ram_writer.sv
// tb/tb_acq_ram_writer.sv - scoreboard testbench for acq_ram_writer
module tb_acq_ram_writer;

    localparam int BITS = 16;
    localparam int AB   = 4;

    logic            CLOCK = 1'b0;
    logic            RESET = 1'b0;
    logic            START = 1'b0;
    logic            ABORT = 1'b0;
    logic            WAIT_INDEX = 1'b0;
    logic [7:0]      INDEX_STOP = 8'd0;
    logic [BITS-1:0] RD_DATA = '0;
    logic            RD_WRITE = 1'b0;
    logic            RUN;
    logic [AB-1:0]   SRAM_A;
    logic [BITS-1:0] SRAM_D;
    logic            SRAM_WE_N;
    logic            BUSY;
    logic [AB-1:0]   WORDS;
    logic            FULL;
    logic            OVERRUN;

    typedef struct packed {
        logic [AB-1:0]   a;
        logic [BITS-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  vec_cnt = 0;
    int  err_cnt = 0;

    acq_ram_writer #(
        .BITS            (BITS),
        .ADDR_BITS       (AB),
        .FIFO_DEPTH_LOG2 (3)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .START      (START),
        .ABORT      (ABORT),
        .WAIT_INDEX (WAIT_INDEX),
        .INDEX_STOP (INDEX_STOP),
        .RD_DATA    (RD_DATA),
        .RD_WRITE   (RD_WRITE),
        .RUN        (RUN),
        .SRAM_A     (SRAM_A),
        .SRAM_D     (SRAM_D),
        .SRAM_WE_N  (SRAM_WE_N),
        .BUSY       (BUSY),
        .WORDS      (WORDS),
        .FULL       (FULL),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    // SRAM monitor: WE_N is low for exactly one cycle per committed word
    always @(negedge CLOCK) begin
        if (RESET && SRAM_WE_N === 1'b0) got_q.push_back({SRAM_A, SRAM_D});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic pulse_abort();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (3) tick();
        vec_cnt++;
        if ({RUN, BUSY, SRAM_WE_N, FULL, OVERRUN} !== 5'b00100) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b expected 00100", {RUN, BUSY, SRAM_WE_N, FULL, OVERRUN});
        end
        vec_cnt++;
        if ({SRAM_A, SRAM_D, WORDS} !== '0) begin
            err_cnt++;
            $display("FAIL reset_bus: got a=%h d=%h words=%h expected all zero", SRAM_A, SRAM_D, WORDS);
        end
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_wait_index();
        logic [BITS-1:0] w [5];
        bit ok;
        w = '{16'h0010, 16'h4020, 16'h8005, 16'h4030, 16'h8001};
        exp_q.delete();
        got_q.delete();
        WAIT_INDEX = 1'b1;
        INDEX_STOP = 8'd2;
        pulse_start();
        vec_cnt++;
        if (RUN !== 1'b1) begin
            err_cnt++;
            $display("FAIL waitidx_run_on: got %b expected 1", RUN);
        end
        for (int i = 0; i < 5; i++) begin
            RD_DATA  = w[i];
            RD_WRITE = 1'b1;
            if (i >= 1 && i <= 3) exp_q.push_back({AB'(i - 1), w[i]});
            @(negedge CLOCK);
            if (i == 3) begin
                vec_cnt++;
                if (RUN !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL waitidx_run_last: got %b expected 1", RUN);
                end
            end
            if (i == 4) begin
                vec_cnt++;
                if (RUN !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL waitidx_run_fall: got %b expected 0", RUN);
                end
            end
            tick();
        end
        RD_WRITE = 1'b0;
        wait_done(ok);
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL waitidx_done: got busy expected done");
        end
        vec_cnt++;
        if (WORDS !== AB'(3) || RUN !== 1'b0) begin
            err_cnt++;
            $display("FAIL waitidx_words: got words=%0d run=%b expected words=3 run=0", WORDS, RUN);
        end
        vec_cnt++;
        if (got_q.size() != exp_q.size()) begin
            err_cnt++;
            $display("FAIL waitidx_count: got %0d writes expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            wr_t g = got_q.pop_front();
            vec_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL waitidx_sram: got a=%h d=%h expected a=%h d=%h", g.a, g.d, e.a, e.d);
            end
        end
        WAIT_INDEX = 1'b0;
        INDEX_STOP = 8'd0;
    endtask

    // From empty with one word per cycle, the writer pops on cycles 1, 5 and 9,
    // so the FIFO is full with no pop on cycle 11: only that word is lost.
    task automatic test_overrun();
        bit ok;
        exp_q.delete();
        got_q.delete();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            RD_DATA  = 16'h8000 | 16'(i * 3);
            RD_WRITE = 1'b1;
            if (i < 11) exp_q.push_back({AB'(i), 16'h8000 | 16'(i * 3)});
            tick();
        end
        RD_WRITE = 1'b0;
        vec_cnt++;
        if (OVERRUN !== 1'b1) begin
            err_cnt++;
            $display("FAIL overrun_flag: got %b expected 1", OVERRUN);
        end
        repeat (60) tick();
        pulse_abort();
        wait_done(ok);
        vec_cnt++;
        if (!ok || WORDS !== AB'(11)) begin
            err_cnt++;
            $display("FAIL overrun_words: got words=%0d done=%b expected words=11 done=1", WORDS, ok);
        end
        vec_cnt++;
        if (got_q.size() != exp_q.size()) begin
            err_cnt++;
            $display("FAIL overrun_count: got %0d writes expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            wr_t g = got_q.pop_front();
            vec_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL overrun_sram: got a=%h d=%h expected a=%h d=%h", g.a, g.d, e.a, e.d);
            end
        end
    endtask

    task automatic test_restart();
        bit ok;
        exp_q.delete();
        got_q.delete();
        pulse_start();
        vec_cnt++;
        if ({WORDS, FULL, OVERRUN, BUSY, RUN} !== {AB'(0), 4'b0011}) begin
            err_cnt++;
            $display("FAIL restart_clear: got words=%0d full=%b ovr=%b busy=%b run=%b expected 0 0 0 1 1",
                     WORDS, FULL, OVERRUN, BUSY, RUN);
        end
        RD_DATA  = 16'h8123;
        RD_WRITE = 1'b1;
        exp_q.push_back({AB'(0), 16'h8123});
        tick();
        RD_WRITE = 1'b0;
        repeat (8) tick();
        pulse_abort();
        wait_done(ok);
        vec_cnt++;
        if (!ok || WORDS !== AB'(1)) begin
            err_cnt++;
            $display("FAIL restart_words: got words=%0d done=%b expected words=1 done=1", WORDS, ok);
        end
        vec_cnt++;
        if (got_q.size() != 1) begin
            err_cnt++;
            $display("FAIL restart_count: got %0d writes expected 1", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            wr_t g = got_q.pop_front();
            vec_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL restart_sram: got a=%h d=%h expected a=%h d=%h", g.a, g.d, e.a, e.d);
            end
        end
    endtask

    // 4-bit address: 16 words fill the SRAM; WORDS pins at all-ones
    task automatic test_full();
        bit ok;
        exp_q.delete();
        got_q.delete();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            RD_DATA  = 16'h8000 | 16'(i << 4);
            RD_WRITE = 1'b1;
            if (i < 16) exp_q.push_back({AB'(i), 16'h8000 | 16'(i << 4)});
            tick();
            RD_WRITE = 1'b0;
            repeat (4) tick();
        end
        wait_done(ok);
        vec_cnt++;
        if (!ok || FULL !== 1'b1) begin
            err_cnt++;
            $display("FAIL full_flag: got full=%b done=%b expected 1 1", FULL, ok);
        end
        vec_cnt++;
        if (WORDS !== {AB{1'b1}} || OVERRUN !== 1'b0) begin
            err_cnt++;
            $display("FAIL full_words: got words=%h ovr=%b expected words=f ovr=0", WORDS, OVERRUN);
        end
        vec_cnt++;
        if (got_q.size() != exp_q.size()) begin
            err_cnt++;
            $display("FAIL full_count: got %0d writes expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            wr_t g = got_q.pop_front();
            vec_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL full_sram: got a=%h d=%h expected a=%h d=%h", g.a, g.d, e.a, e.d);
            end
        end
    endtask

    // Words at c0..c4; word 1 strobes on c7 with words 2..4 queued; abort on c7
    task automatic test_abort();
        exp_q.delete();
        got_q.delete();
        pulse_start();
        vec_cnt++;
        if (FULL !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_start_full: got %b expected 0", FULL);
        end
        for (int i = 0; i < 5; i++) begin
            RD_DATA  = 16'h8a00 | 16'(i);
            RD_WRITE = 1'b1;
            if (i < 2) exp_q.push_back({AB'(i), 16'h8a00 | 16'(i)});
            tick();
        end
        RD_WRITE = 1'b0;
        repeat (2) tick();
        ABORT = 1'b1;
        @(negedge CLOCK);
        vec_cnt++;
        if (SRAM_WE_N !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_strobe: got we_n=%b expected 0", SRAM_WE_N);
        end
        tick();
        ABORT = 1'b0;
        @(negedge CLOCK);
        vec_cnt++;
        if ({RUN, SRAM_WE_N, BUSY} !== 3'b011) begin
            err_cnt++;
            $display("FAIL abort_hold: got run/we_n/busy=%b expected 011", {RUN, SRAM_WE_N, BUSY});
        end
        tick();
        @(negedge CLOCK);
        vec_cnt++;
        if (BUSY !== 1'b1) begin
            err_cnt++;
            $display("FAIL abort_busy: got %b expected 1", BUSY);
        end
        tick();
        @(negedge CLOCK);
        vec_cnt++;
        if (BUSY !== 1'b0 || WORDS !== AB'(2)) begin
            err_cnt++;
            $display("FAIL abort_done: got busy=%b words=%0d expected 0 2", BUSY, WORDS);
        end
        repeat (10) tick();
        vec_cnt++;
        if (got_q.size() != exp_q.size()) begin
            err_cnt++;
            $display("FAIL abort_count: got %0d writes expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            wr_t g = got_q.pop_front();
            vec_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL abort_sram: got a=%h d=%h expected a=%h d=%h", g.a, g.d, e.a, e.d);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        bit seen;
        exp_q.delete();
        got_q.delete();
        pulse_start();
        RD_DATA  = 16'h8777;
        RD_WRITE = 1'b1;
        tick();
        RD_WRITE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (SRAM_WE_N === 1'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        vec_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL midwrite_strobe: got we_n=%b expected 0 within 10 cycles", SRAM_WE_N);
        end
        RESET = 1'b0;
        #1;
        vec_cnt++;
        if ({RUN, BUSY, SRAM_WE_N, FULL, OVERRUN} !== 5'b00100 || {SRAM_A, SRAM_D, WORDS} !== '0) begin
            err_cnt++;
            $display("FAIL midwrite_reset: got ctrl=%b a=%h d=%h words=%h expected 00100 0 0 0",
                     {RUN, BUSY, SRAM_WE_N, FULL, OVERRUN}, SRAM_A, SRAM_D, WORDS);
        end
        repeat (2) tick();
        RESET = 1'b1;
        repeat (12) tick();
        vec_cnt++;
        if (got_q.size() != 0 || BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL midwrite_quiet: got %0d writes busy=%b expected 0 0", got_q.size(), BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_wait_index();
        test_overrun();
        test_restart();
        test_full();
        test_abort();
        test_reset_midwrite();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
